// File: rtl/dbus_ctrl_if.sv
// Shared access-type package and the SRAM-like data-bus interface.
// The controller uses the master modport; a bus slave or testbench uses the slave modport.
package common;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        MEM_LW,
        MEM_LH,
        MEM_LHU,
        MEM_LB,
        MEM_LBU,
        MEM_SW,
        MEM_SH,
        MEM_SB
    } mem_t;
endpackage

interface dbus_if;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    modport master (
        output d_req,
        output d_wr,
        output d_size,
        output d_addr,
        output d_wstrb,
        output d_wdata,
        input  d_addr_ok,
        input  d_data_ok,
        input  d_rdata
    );

    modport slave (
        input  d_req,
        input  d_wr,
        input  d_size,
        input  d_addr,
        input  d_wstrb,
        input  d_wdata,
        output d_addr_ok,
        output d_data_ok,
        output d_rdata
    );
endinterface

// File: rtl/dbus_ctrl.sv
// Data-bus access sequencer: aligns stores, traps misaligned addresses, runs the
// addr_ok/data_ok handshake and stalls the memory stage until the access completes.
module dbus_ctrl
    import common::*;
(
    input  logic  clk,
    input  logic  resetn,

    input  logic  m_valid_i,
    input  mem_t  m_mem_type_i,
    input  word_t m_addr_i,
    input  word_t m_wdata_i,
    input  logic  m_flush_i,

    output logic  stall_o,
    output logic  m_done_o,
    output word_t m_rdata_o,
    output logic  adel_o,
    output logic  ades_o,

    dbus_if.master dbus
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic   discard_q, discard_d;
    word_t  rdata_q, rdata_d;

    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    word_t       addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    word_t       wdata_q, wdata_d;

    // Decoded view of the incoming instruction
    logic        is_store;
    logic [1:0]  req_size;
    logic        misaligned;
    logic [3:0]  req_wstrb;
    word_t       req_wdata;
    logic        start;

    always_comb begin
        is_store  = 1'b0;
        req_size  = 2'd0;
        req_wstrb = 4'b0000;
        req_wdata = '0;
        unique case (m_mem_type_i)
            MEM_LW: req_size = 2'd2;
            MEM_LH, MEM_LHU: req_size = 2'd1;
            MEM_LB, MEM_LBU: req_size = 2'd0;
            MEM_SW: begin
                is_store  = 1'b1;
                req_size  = 2'd2;
                req_wstrb = 4'b1111;
                req_wdata = m_wdata_i;
            end
            MEM_SH: begin
                is_store = 1'b1;
                req_size = 2'd1;
                if (m_addr_i[1]) begin
                    req_wstrb = 4'b1100;
                    req_wdata = {m_wdata_i[15:0], 16'h0000};
                end else begin
                    req_wstrb = 4'b0011;
                    req_wdata = m_wdata_i;
                end
            end
            MEM_SB: begin
                is_store  = 1'b1;
                req_size  = 2'd0;
                req_wstrb = 4'b0001 << m_addr_i[1:0];
                req_wdata = m_wdata_i << {m_addr_i[1:0], 3'b000};
            end
            default: begin
                is_store = 1'b0;
                req_size = 2'd0;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if (req_size == 2'd2) begin
            misaligned = (m_addr_i[1:0] != 2'b00);
        end else if (req_size == 2'd1) begin
            misaligned = m_addr_i[0];
        end
    end

    assign adel_o = (state_q == StIdle) && m_valid_i && misaligned && !is_store;
    assign ades_o = (state_q == StIdle) && m_valid_i && misaligned && is_store;
    assign start  = (state_q == StIdle) && m_valid_i && !misaligned && !m_flush_i;

    // Bus fields are captured only when a request starts and held until the next one.
    always_comb begin
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        if (start) begin
            wr_d    = is_store;
            size_d  = req_size;
            addr_d  = m_addr_i;
            wstrb_d = req_wstrb;
            wdata_d = req_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        rdata_d   = rdata_q;
        stall_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                discard_d = 1'b0;
                if (start) begin
                    state_d = StReq;
                    stall_o = 1'b1;
                end
            end
            StReq: begin
                stall_o = 1'b1;
                if (dbus.d_addr_ok) begin
                    if (dbus.d_data_ok) begin
                        if (m_flush_i) begin
                            // Data already returned but the instruction is gone: drop it.
                            state_d   = StIdle;
                            discard_d = 1'b0;
                        end else begin
                            state_d = StDone;
                            rdata_d = wr_q ? '0 : dbus.d_rdata;
                        end
                    end else begin
                        state_d   = StWait;
                        discard_d = m_flush_i;
                    end
                end else if (m_flush_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                stall_o = 1'b1;
                if (dbus.d_data_ok) begin
                    if (discard_q || m_flush_i) begin
                        state_d   = StIdle;
                        discard_d = 1'b0;
                    end else begin
                        state_d = StDone;
                        rdata_d = wr_q ? '0 : dbus.d_rdata;
                    end
                end else begin
                    discard_d = discard_q | m_flush_i;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            rdata_q   <= rdata_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
        end
    end

    assign m_done_o     = (state_q == StDone);
    assign m_rdata_o    = rdata_q;
    assign dbus.d_req   = (state_q == StReq);
    assign dbus.d_wr    = wr_q;
    assign dbus.d_size  = size_q;
    assign dbus.d_addr  = addr_q;
    assign dbus.d_wstrb = wstrb_q;
    assign dbus.d_wdata = wdata_q;

    a_bus_stable: assert property (@(posedge clk) disable iff (!resetn)
        dbus.d_req && $past(dbus.d_req) |->
            $stable(dbus.d_addr) && $stable(dbus.d_wdata) && $stable(dbus.d_wstrb)
            && $stable(dbus.d_size) && $stable(dbus.d_wr));

    a_done_no_stall: assert property (@(posedge clk) disable iff (!resetn)
        m_done_o |-> !stall_o);

    a_read_no_strobe: assert property (@(posedge clk) disable iff (!resetn)
        dbus.d_req && !dbus.d_wr |-> dbus.d_wstrb == 4'b0000);

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: table of single-access vectors with immediate acks, plus
// hand-written sequences for slow acks, flushes and asynchronous reset.
module tb_dbus_ctrl;
    import common::*;

    logic  clk = 1'b0;
    logic  resetn;
    logic  m_valid;
    mem_t  m_mem_type;
    word_t m_addr;
    word_t m_wdata;
    logic  m_flush;
    logic  stall;
    logic  m_done;
    word_t m_rdata;
    logic  adel;
    logic  ades;

    dbus_if bus ();

    dbus_ctrl u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .m_valid_i    (m_valid),
        .m_mem_type_i (m_mem_type),
        .m_addr_i     (m_addr),
        .m_wdata_i    (m_wdata),
        .m_flush_i    (m_flush),
        .stall_o      (stall),
        .m_done_o     (m_done),
        .m_rdata_o    (m_rdata),
        .adel_o       (adel),
        .ades_o       (ades),
        .dbus         (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (m_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        mem_t        typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic [3:0]  wstrb;
        logic [31:0] exp_wdata;
        logic [1:0]  size;
    } vec_t;

    vec_t vecs[14];

    function automatic logic is_st(input mem_t t);
        return (t == MEM_SW) || (t == MEM_SH) || (t == MEM_SB);
    endfunction

    // Called at a negedge with the DUT idle; acks arrive in the issue cycle.
    task automatic run_vec(input vec_t v);
        int   d0;
        logic legal;
        legal = !(v.adel || v.ades);
        d0 = done_cnt;
        m_valid = 1'b1; m_mem_type = v.typ; m_addr = v.addr; m_wdata = v.wdata;
        m_flush = 1'b0;
        #1;
        chk("adel", {31'b0, adel}, {31'b0, v.adel});
        chk("ades", {31'b0, ades}, {31'b0, v.ades});
        chk("stall_idle", {31'b0, stall}, {31'b0, legal});
        @(negedge clk);
        if (legal) begin
            #1;
            chk("d_req", {31'b0, bus.d_req}, 32'd1);
            chk("d_wr", {31'b0, bus.d_wr}, {31'b0, is_st(v.typ)});
            chk("d_size", {30'b0, bus.d_size}, {30'b0, v.size});
            chk("d_addr", bus.d_addr, v.addr);
            chk("d_wstrb", {28'b0, bus.d_wstrb}, {28'b0, v.wstrb});
            chk("d_wdata", bus.d_wdata, v.exp_wdata);
            chk("stall_req", {31'b0, stall}, 32'd1);
            bus.d_addr_ok = 1'b1; bus.d_data_ok = 1'b1; bus.d_rdata = v.rdata;
            @(negedge clk);
            bus.d_addr_ok = 1'b0; bus.d_data_ok = 1'b0; bus.d_rdata = 32'h0;
            m_valid = 1'b0;
            #1;
            chk("m_done", {31'b0, m_done}, 32'd1);
            chk("stall_done", {31'b0, stall}, 32'd0);
            chk("m_rdata", m_rdata, is_st(v.typ) ? 32'h0 : v.rdata);
            @(negedge clk);
            #1;
            chk("done_once", done_cnt - d0, 32'd1);
            chk("d_req_idle", {31'b0, bus.d_req}, 32'd0);
        end else begin
            m_valid = 1'b0;
            #1;
            chk("no_req", {31'b0, bus.d_req}, 32'd0);
            chk("no_done", done_cnt - d0, 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        int   d0;
        vecs[0]  = '{MEM_SW,  32'h1000, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 4'hF, 32'hDEADBEEF, 2'd2};
        vecs[1]  = '{MEM_SB,  32'h1003, 32'h000000A5, 32'h0, 1'b0, 1'b0, 4'h8, 32'hA5000000, 2'd0};
        vecs[2]  = '{MEM_SH,  32'h1002, 32'h00001234, 32'h0, 1'b0, 1'b0, 4'hC, 32'h12340000, 2'd1};
        vecs[3]  = '{MEM_SH,  32'h1000, 32'hABCD1234, 32'h0, 1'b0, 1'b0, 4'h3, 32'hABCD1234, 2'd1};
        vecs[4]  = '{MEM_SB,  32'h1001, 32'h11223344, 32'h0, 1'b0, 1'b0, 4'h2, 32'h22334400, 2'd0};
        vecs[5]  = '{MEM_LW,  32'h2000, 32'h0, 32'h12345678, 1'b0, 1'b0, 4'h0, 32'h0, 2'd2};
        vecs[6]  = '{MEM_LH,  32'h2001, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 2'd1};
        vecs[7]  = '{MEM_SW,  32'h2002, 32'h55, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd2};
        vecs[8]  = '{MEM_LHU, 32'h2002, 32'h0, 32'h89ABCDEF, 1'b0, 1'b0, 4'h0, 32'h0, 2'd1};
        vecs[9]  = '{MEM_LB,  32'h2003, 32'h0, 32'h55AA55AA, 1'b0, 1'b0, 4'h0, 32'h0, 2'd0};
        vecs[10] = '{MEM_SH,  32'h2003, 32'h77, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd1};
        vecs[11] = '{MEM_LBU, 32'h2001, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b0, 4'h0, 32'h0, 2'd0};
        vecs[12] = '{MEM_SW,  32'h3001, 32'h99, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd2};
        vecs[13] = '{MEM_LW,  32'h3002, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 2'd2};

        resetn = 1'b0; m_valid = 1'b0; m_mem_type = MEM_LW; m_addr = '0; m_wdata = '0;
        m_flush = 1'b0;
        bus.d_addr_ok = 1'b0; bus.d_data_ok = 1'b0; bus.d_rdata = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_d_req", {31'b0, bus.d_req}, 32'd0);
        chk("rst_m_done", {31'b0, m_done}, 32'd0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_d_addr", bus.d_addr, 32'h0);
        chk("rst_d_wstrb", {28'b0, bus.d_wstrb}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // LW with one cycle of addr_ok wait, then data_ok 4 cycles after addr_ok
        d0 = done_cnt;
        m_valid = 1'b1; m_mem_type = MEM_LW; m_addr = 32'h2000; m_wdata = 32'h0;
        #1;
        chk("lw_stall_idle", {31'b0, stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("lw_req0", {31'b0, bus.d_req}, 32'd1);
        @(negedge clk);
        #1;
        chk("lw_req1", {31'b0, bus.d_req}, 32'd1);
        chk("lw_addr_hold", bus.d_addr, 32'h2000);
        bus.d_addr_ok = 1'b1;
        @(negedge clk);
        bus.d_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_stall", {31'b0, stall}, 32'd1);
            chk("lw_wait_wstrb", {28'b0, bus.d_wstrb}, 32'h0);
            chk("lw_wait_req", {31'b0, bus.d_req}, 32'd0);
            @(negedge clk);
        end
        bus.d_data_ok = 1'b1; bus.d_rdata = 32'hCAFEF00D;
        #1;
        chk("lw_pre_done", {31'b0, m_done}, 32'd0);
        @(negedge clk);
        bus.d_data_ok = 1'b0; bus.d_rdata = 32'h0; m_valid = 1'b0;
        #1;
        chk("lw_done", {31'b0, m_done}, 32'd1);
        chk("lw_rdata", m_rdata, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        chk("lw_done_once", done_cnt - d0, 32'd1);

        // Flush in REQ before addr_ok
        d0 = done_cnt;
        m_valid = 1'b1; m_mem_type = MEM_LW; m_addr = 32'h2004;
        @(negedge clk);
        m_flush = 1'b1;
        #1;
        chk("fr_req", {31'b0, bus.d_req}, 32'd1);
        @(negedge clk);
        m_flush = 1'b0; m_valid = 1'b0;
        #1;
        chk("fr_req_drop", {31'b0, bus.d_req}, 32'd0);
        chk("fr_stall", {31'b0, stall}, 32'd0);
        chk("fr_rdata", m_rdata, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        chk("fr_no_done", done_cnt - d0, 32'd0);

        // Flush in WAIT: drain data_ok silently
        m_valid = 1'b1; m_mem_type = MEM_LW; m_addr = 32'h2008;
        @(negedge clk);
        bus.d_addr_ok = 1'b1;
        @(negedge clk);
        bus.d_addr_ok = 1'b0; m_flush = 1'b1;
        #1;
        chk("fw_stall0", {31'b0, stall}, 32'd1);
        @(negedge clk);
        m_flush = 1'b0; m_valid = 1'b0;
        #1;
        chk("fw_drain_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        bus.d_data_ok = 1'b1; bus.d_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        bus.d_data_ok = 1'b0; bus.d_rdata = 32'h0;
        #1;
        chk("fw_no_mdone", {31'b0, m_done}, 32'd0);
        chk("fw_rdata_kept", m_rdata, 32'hCAFEF00D);
        chk("fw_stall_end", {31'b0, stall}, 32'd0);
        chk("fw_no_done", done_cnt - d0, 32'd0);
        @(negedge clk);
        v = '{MEM_LW, 32'h200C, 32'h0, 32'h600DF00D, 1'b0, 1'b0, 4'h0, 32'h0, 2'd2};
        run_vec(v);

        // Asynchronous reset while waiting for data
        d0 = done_cnt;
        m_valid = 1'b1; m_mem_type = MEM_SW; m_addr = 32'h2010; m_wdata = 32'h13572468;
        @(negedge clk);
        bus.d_addr_ok = 1'b1;
        @(negedge clk);
        bus.d_addr_ok = 1'b0;
        #1;
        chk("rw_wait_addr", bus.d_addr, 32'h2010);
        #2;
        resetn = 1'b0; m_valid = 1'b0;
        #1;
        chk("rw_d_addr", bus.d_addr, 32'h0);
        chk("rw_d_wdata", bus.d_wdata, 32'h0);
        chk("rw_d_wstrb", {28'b0, bus.d_wstrb}, 32'h0);
        chk("rw_d_wr", {31'b0, bus.d_wr}, 32'h0);
        chk("rw_m_rdata", m_rdata, 32'h0);
        chk("rw_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rw_no_done", done_cnt - d0, 32'd0);
        chk("rw_idle_req", {31'b0, bus.d_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dbus_ctrl.md
# dbus_ctrl

Data-bus access sequencer between the memory stage and the SRAM-like data bus. It takes one load or store per instruction. Stores are aligned into a bus word and byte strobes; misaligned addresses are trapped. The block runs the addr_ok/data_ok handshake, stalls the pipeline until the access completes, and returns the raw read word for load extension downstream.

## Interface
- No parameters; data/address width fixed at 32 (word_t), access type is mem_t from common.
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m_valid  in  1  memory stage holds a load/store this cycle
- m_mem_type  in  mem_t  MEM_LW/LH/LHU/LB/LBU/SW/SH/SB
- m_addr  in  32  byte address
- m_wdata  in  32  unaligned store data (register value, LSB-justified)
- m_flush  in  1  pipeline flush; cancels the current instruction
- stall  out  1  hold memory stage and upstream
- m_done  out  1  one-cycle pulse: access complete, m_rdata valid
- m_rdata  out  32  raw bus read word (zero for stores)
- adel / ades  out  1 each  load / store address error (combinational)
- d_req  out  1  bus request
- d_wr  out  1  1 = write
- d_size  out  2  0 byte, 1 half, 2 word
- d_addr  out  32  byte address
- d_wstrb  out  4  byte write enables (0000 on reads)
- d_wdata  out  32  aligned store data
- d_addr_ok  in  1  request accepted
- d_data_ok  in  1  data phase complete
- d_rdata  in  32  read data, valid with d_data_ok

## Operation
- Alignment check (IDLE only, gated by m_valid):
  - word requires addr[1:0]=00.
  - half requires addr[0]=0.
  - byte is always legal.
  - Violation raises adel (load) or ades (store) and issues no request. stall=0.
- Store data/strobe:
  - SW: data unchanged, wstrb 1111.
  - SH: addr[1]=0 gives data unchanged, wstrb 0011. addr[1]=1 gives {wd[15:0],16'h0}, wstrb 1100.
  - SB: data = wd << (8*addr[1:0]), wstrb = 0001 << addr[1:0].
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if m_valid & legal & !m_flush, latch addr/size/wr/wstrb/wdata into registers, go REQ.
  - REQ: d_req=1, bus fields driven from registers, held stable.
    - addr_ok & data_ok in the same cycle: go DONE.
    - addr_ok alone: go WAIT.
    - m_flush without addr_ok: go IDLE; request withdrawn.
  - WAIT: on data_ok, latch d_rdata and go DONE. A discarded access goes IDLE instead.
  - DONE: m_done=1, stall=0, go IDLE. The same instruction is never reissued.
- Flush:
  - A flush in REQ with addr_ok in the same cycle, or any flush in WAIT, sets discard.
  - A discarded access drains its data_ok, produces no m_done and writes no m_rdata.
  - discard clears on entering IDLE.
- stall:
  - 1 in IDLE when a legal request is starting.
  - 1 in REQ and WAIT, including discard drain.
  - 0 in DONE and otherwise.

## Timing
- Reset (async, resetn=0): state IDLE, discard 0, all registered outputs 0.
  - d_req=0, m_done=0, m_rdata=0, d_addr/d_wdata/d_wstrb/d_size/d_wr=0.
  - stall/adel/ades follow the combinational rule (0 with m_valid=0).
  - Reset mid-transaction abandons it; no pulse on release.
- Minimum latency:
  - Request issue cycle: d_req asserts in the cycle after m_valid is seen.
  - addr_ok and data_ok both arrive in that issue cycle.
  - m_done pulses in the next cycle.
  - This is 3 cycles, IDLE → REQ → DONE.
- Bus fields change only on IDLE→REQ, and stay constant while d_req=1.
- m_* inputs must stay stable while stall=1. The pipeline advances in the DONE cycle.
- The next instruction's request can start in the cycle after DONE. No back-to-back overlap: at most 1 outstanding transaction.

## Test plan
- SW 0x1000, wd 0xDEADBEEF, addr_ok/data_ok 1 cycle later:
  - d_wstrb 1111, d_wdata 0xDEADBEEF, d_size 2.
  - m_done exactly once; stall high until DONE.
- SB addr 0x1003, wd 0x000000A5: d_wstrb 1000, d_wdata 0xA5000000, d_size 0.
- SH addr 0x1002, wd 0x1234: d_wstrb 1100, d_wdata 0x12340000.
- LW 0x2000, d_rdata 0xCAFEF00D with data_ok 4 cycles after addr_ok:
  - m_rdata 0xCAFEF00D on m_done.
  - d_wstrb 0000; stall held throughout.
- LH addr 0x2001: adel=1, d_req never asserts, stall 0. SW addr 0x2002: ades=1.
- Flush cases on LW:
  - Flush in REQ before addr_ok: d_req drops next cycle, no m_done.
  - Flush in WAIT: data_ok is consumed with no m_done and m_rdata unchanged; the next request starts normally.
  - resetn low mid-WAIT: all outputs 0 immediately.
